execute_stage: RTL and testbench

- EX stage of the 5-stage MIPS pipeline. It sits directly downstream of the ID/EX pipeline register.
- Contains the forwarding operand muxes, the ALU, and an iterative shift-add multiplier, all feeding a registered EX/MEM boundary.
- Asserts a stall request to the hazard unit while a multi-cycle MUL is executing.

---
 rtl/execute_stage.sv | 247 ++++++++++++++++++++++++
 tb/tb_execute_stage.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// execute_stage: EX stage of the 5-stage MIPS pipeline.
// Forwarding operand muxes, ALU and an optional iterative shift-add
// multiplier, all feeding the registered EX/MEM boundary.
// Build option: define EXEC_MUL_EN to include the multi-cycle MUL unit.
// Without it, ALU control 011 produces 0 in a single cycle and mul_busy is 0.
`timescale 1ns/1ps

module execute_stage #(
    parameter int data_width     = 32,
    parameter int alu_ctrl_width = 3,
    parameter int op_width       = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      reg_write_e,
    input  logic                      mem2reg_e,
    input  logic                      mem_wr_e,
    input  logic [alu_ctrl_width-1:0] alu_control_e,
    input  logic                      alu_src_e,
    input  logic                      reg_dst_e,
    input  logic [data_width-1:0]     rd1_e,
    input  logic [data_width-1:0]     rd2_e,
    input  logic [op_width-1:0]       rt_e,
    input  logic [op_width-1:0]       rd_e,
    input  logic [data_width-1:0]     sign_extend_e,
    input  logic [1:0]                forward_a_e,
    input  logic [1:0]                forward_b_e,
    input  logic [data_width-1:0]     result_w,
    output logic [op_width-1:0]       write_reg_e,
    output logic                      mul_busy,
    output logic                      reg_write_m,
    output logic                      mem2reg_m,
    output logic                      mem_wr_m,
    output logic [data_width-1:0]     alu_out_m,
    output logic [data_width-1:0]     write_data_m,
    output logic [op_width-1:0]       write_reg_m
);

    // ALU operation encodings
    localparam logic [alu_ctrl_width-1:0] ALU_AND = alu_ctrl_width'(3'b000);
    localparam logic [alu_ctrl_width-1:0] ALU_OR  = alu_ctrl_width'(3'b001);
    localparam logic [alu_ctrl_width-1:0] ALU_ADD = alu_ctrl_width'(3'b010);
    localparam logic [alu_ctrl_width-1:0] ALU_MUL = alu_ctrl_width'(3'b011);
    localparam logic [alu_ctrl_width-1:0] ALU_XOR = alu_ctrl_width'(3'b100);
    localparam logic [alu_ctrl_width-1:0] ALU_NOP = alu_ctrl_width'(3'b101);
    localparam logic [alu_ctrl_width-1:0] ALU_SUB = alu_ctrl_width'(3'b110);
    localparam logic [alu_ctrl_width-1:0] ALU_SLT = alu_ctrl_width'(3'b111);

    // Forwarding mux select encodings
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    logic [data_width-1:0] w_src_a;
    logic [data_width-1:0] w_fwd_b;
    logic [data_width-1:0] w_src_b;
    logic [op_width-1:0]   w_write_reg;
    logic [data_width-1:0] w_alu_result;
    logic [data_width-1:0] w_ex_result;
    logic                  w_mul_busy;
    logic                  w_mul_done;
    logic [data_width-1:0] w_mul_result;

    // Forwarding mux for operand A; 11 falls back to the register file value
    always_comb begin
        w_src_a = rd1_e;
        case (forward_a_e)
            FWD_RF:  w_src_a = rd1_e;
            FWD_WB:  w_src_a = result_w;
            FWD_MEM: w_src_a = alu_out_m;
            default: w_src_a = rd1_e;
        endcase
    end

    // Forwarding mux for operand B (also the store data), same encoding as A
    always_comb begin
        w_fwd_b = rd2_e;
        case (forward_b_e)
            FWD_RF:  w_fwd_b = rd2_e;
            FWD_WB:  w_fwd_b = result_w;
            FWD_MEM: w_fwd_b = alu_out_m;
            default: w_fwd_b = rd2_e;
        endcase
    end

    // Immediate select for operand B and destination register select
    always_comb begin
        if (alu_src_e) begin
            w_src_b = sign_extend_e;
        end else begin
            w_src_b = w_fwd_b;
        end
        if (reg_dst_e) begin
            w_write_reg = rd_e;
        end else begin
            w_write_reg = rt_e;
        end
    end

    assign write_reg_e = w_write_reg;

    // Single-cycle ALU; MUL is produced by the multiplier, so the ALU yields 0 for it
    always_comb begin
        w_alu_result = {data_width{1'b0}};
        case (alu_control_e)
            ALU_AND: w_alu_result = w_src_a & w_src_b;
            ALU_OR:  w_alu_result = w_src_a | w_src_b;
            ALU_ADD: w_alu_result = w_src_a + w_src_b;
            ALU_SUB: w_alu_result = w_src_a - w_src_b;
            ALU_XOR: w_alu_result = w_src_a ^ w_src_b;
            ALU_SLT: w_alu_result = {{(data_width-1){1'b0}},
                                     ($signed(w_src_a) < $signed(w_src_b))};
            ALU_MUL: w_alu_result = {data_width{1'b0}};
            ALU_NOP: w_alu_result = {data_width{1'b0}};
            default: w_alu_result = {data_width{1'b0}};
        endcase
    end

`ifdef EXEC_MUL_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } mul_state_t;

    localparam int                CNT_W     = $clog2(data_width + 1);
    localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(data_width - 1);

    mul_state_t            r_state;
    logic [data_width-1:0] r_mcand;
    logic [data_width-1:0] r_mplier;
    logic [data_width-1:0] r_acc;
    logic [CNT_W-1:0]      r_cnt;
    logic                  w_is_mul;

    assign w_is_mul = (alu_control_e == ALU_MUL);

    // Shift-add multiplier FSM: operands frozen at start, fixed data_width iterations
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_mcand  <= {data_width{1'b0}};
            r_mplier <= {data_width{1'b0}};
            r_acc    <= {data_width{1'b0}};
            r_cnt    <= {CNT_W{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_is_mul) begin
                        r_mcand  <= w_src_a;
                        r_mplier <= w_src_b;
                        r_acc    <= {data_width{1'b0}};
                        r_cnt    <= {CNT_W{1'b0}};
                        r_state  <= ST_BUSY;
                    end else begin
                        r_state  <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (r_mplier[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end else begin
                        r_acc <= r_acc;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (r_cnt == LAST_ITER) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_state <= ST_BUSY;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Stall while a MUL is starting or iterating; never while reset is held
    always_comb begin
        w_mul_busy   = 1'b0;
        w_mul_done   = 1'b0;
        w_mul_result = r_acc;
        if (!reset) begin
            w_mul_busy = 1'b0;
        end else if (r_state == ST_BUSY) begin
            w_mul_busy = 1'b1;
        end else if (r_state == ST_IDLE) begin
            w_mul_busy = w_is_mul;
        end else begin
            w_mul_busy = 1'b0;
        end
        if (r_state == ST_DONE) begin
            w_mul_done = 1'b1;
        end else begin
            w_mul_done = 1'b0;
        end
    end
`else
    assign w_mul_busy   = 1'b0;
    assign w_mul_done   = 1'b0;
    assign w_mul_result = {data_width{1'b0}};
`endif

    assign mul_busy = w_mul_busy;

    // Result presented to EX/MEM: the product in the DONE cycle, else the ALU output
    always_comb begin
        if (w_mul_done) begin
            w_ex_result = w_mul_result;
        end else begin
            w_ex_result = w_alu_result;
        end
    end

    // EX/MEM pipeline register; loads a bubble while the multiplier stalls the pipe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reg_write_m  <= 1'b0;
            mem2reg_m    <= 1'b0;
            mem_wr_m     <= 1'b0;
            alu_out_m    <= {data_width{1'b0}};
            write_data_m <= {data_width{1'b0}};
            write_reg_m  <= {op_width{1'b0}};
        end else if (w_mul_busy) begin
            reg_write_m  <= 1'b0;
            mem2reg_m    <= 1'b0;
            mem_wr_m     <= 1'b0;
            alu_out_m    <= {data_width{1'b0}};
            write_data_m <= {data_width{1'b0}};
            write_reg_m  <= {op_width{1'b0}};
        end else begin
            reg_write_m  <= reg_write_e;
            mem2reg_m    <= mem2reg_e;
            mem_wr_m     <= mem_wr_e;
            alu_out_m    <= w_ex_result;
            write_data_m <= w_fwd_b;
            write_reg_m  <= w_write_reg;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed + randomized checks of execute_stage against a
// behavioural reference (plain arithmetic on the architectural rules).
// Honours EXEC_MUL_EN the same way the design does.
`timescale 1ns/1ps

module tb_execute_stage;

`ifdef EXEC_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        reg_write_e, mem2reg_e, mem_wr_e;
    logic [2:0]  alu_control_e;
    logic        alu_src_e, reg_dst_e;
    logic [31:0] rd1_e, rd2_e, sign_extend_e, result_w;
    logic [4:0]  rt_e, rd_e;
    logic [1:0]  forward_a_e, forward_b_e;
    logic [4:0]  write_reg_e;
    logic        mul_busy;
    logic        reg_write_m, mem2reg_m, mem_wr_m;
    logic [31:0] alu_out_m, write_data_m;
    logic [4:0]  write_reg_m;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_alu = 32'd0;   // model of alu_out_m as the pipeline sees it

    execute_stage dut (
        .clk(clk), .reset(reset),
        .reg_write_e(reg_write_e), .mem2reg_e(mem2reg_e), .mem_wr_e(mem_wr_e),
        .alu_control_e(alu_control_e), .alu_src_e(alu_src_e), .reg_dst_e(reg_dst_e),
        .rd1_e(rd1_e), .rd2_e(rd2_e), .rt_e(rt_e), .rd_e(rd_e),
        .sign_extend_e(sign_extend_e),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e), .result_w(result_w),
        .write_reg_e(write_reg_e), .mul_busy(mul_busy),
        .reg_write_m(reg_write_m), .mem2reg_m(mem2reg_m), .mem_wr_m(mem_wr_m),
        .alu_out_m(alu_out_m), .write_data_m(write_data_m), .write_reg_m(write_reg_m)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_outputs(input string tag, input logic e_rw, input logic e_m2r,
                               input logic e_mw, input logic [31:0] e_alu,
                               input logic [31:0] e_wd, input logic [4:0] e_wr);
        chk({tag, ".ctrl_m"}, {29'd0, reg_write_m, mem2reg_m, mem_wr_m},
            {29'd0, e_rw, e_m2r, e_mw});
        chk({tag, ".alu_out_m"}, alu_out_m, e_alu);
        chk({tag, ".write_data_m"}, write_data_m, e_wd);
        chk({tag, ".write_reg_m"}, {27'd0, write_reg_m}, {27'd0, e_wr});
    endtask

    // Architectural result of one operation
    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a + b;
            3'd6:    return a - b;
            3'd4:    return a ^ b;
            3'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3:    return MUL_EN ? (a * b) : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] rf,
                                        input logic [31:0] wb);
        if (sel == 2'd1) return wb;
        if (sel == 2'd2) return exp_alu;
        return rf;
    endfunction

    // Issue one instruction into EX and check its EX/MEM result
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] fa, input logic [1:0] fb, input logic [31:0] rw,
                         input logic asrc, input logic [31:0] imm, input string tag);
        logic [31:0] sa, fbv, sb, exp_r, fbv_done;
        logic        c_rw, c_m2r, c_mw;
        logic [4:0]  wr;
        int          busy;
        c_rw = 1'($urandom); c_m2r = 1'($urandom); c_mw = 1'($urandom);
        reg_write_e = c_rw; mem2reg_e = c_m2r; mem_wr_e = c_mw;
        alu_control_e = op; rd1_e = a; rd2_e = b;
        forward_a_e = fa; forward_b_e = fb; result_w = rw;
        alu_src_e = asrc; sign_extend_e = imm;
        rt_e = 5'($urandom); rd_e = 5'($urandom); reg_dst_e = 1'($urandom);
        sa    = fwd(fa, a, rw);
        fbv   = fwd(fb, b, rw);
        sb    = asrc ? imm : fbv;
        exp_r = ref_alu(op, sa, sb);
        wr    = reg_dst_e ? rd_e : rt_e;
        #1;
        chk({tag, ".write_reg_e"}, {27'd0, write_reg_e}, {27'd0, wr});
        if (MUL_EN && op == 3'd3) begin
            busy = 0;
            while (mul_busy === 1'b1 && busy < 100) begin
                busy++;
                @(posedge clk); #1;
                exp_alu = 32'd0;
                if (mul_busy === 1'b1) begin
                    chk({tag, ".bubble_alu"}, alu_out_m, 32'd0);
                    chk({tag, ".bubble_ctrl"},
                        {24'd0, reg_write_m, mem2reg_m, mem_wr_m, write_reg_m}, 32'd0);
                end
                result_w = $urandom;   // late writeback traffic must not disturb the product
            end
            chk({tag, ".busy_cycles"}, busy, 32'd33);
            fbv_done = fwd(fb, b, result_w);
            @(posedge clk); #1;
            exp_alu = exp_r;
            chk_outputs(tag, c_rw, c_m2r, c_mw, exp_r, fbv_done, wr);
        end else begin
            chk({tag, ".mul_busy"}, {31'd0, mul_busy}, 32'd0);
            @(posedge clk); #1;
            exp_alu = exp_r;
            chk_outputs(tag, c_rw, c_m2r, c_mw, exp_r, fbv, wr);
        end
    endtask

    initial begin
        reset = 1'b0;
        reg_write_e = 1'b1; mem2reg_e = 1'b1; mem_wr_e = 1'b1;
        alu_control_e = 3'd3; alu_src_e = 1'b0; reg_dst_e = 1'b1;
        rd1_e = 32'h1234_5678; rd2_e = 32'h9abc_def0; sign_extend_e = 32'd0;
        rt_e = 5'd3; rd_e = 5'd7; forward_a_e = 2'd0; forward_b_e = 2'd0;
        result_w = 32'd0;

        // Reset state, with a MUL sitting in EX
        repeat (2) @(posedge clk);
        #1;
        chk("reset.mul_busy", {31'd0, mul_busy}, 32'd0);
        chk_outputs("reset", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        alu_control_e = 3'd2;
        reset = 1'b1;
        exp_alu = 32'd0;

        // Directed single-cycle ALU cases
        do_op(3'd2, 32'd5, 32'd7, 2'd0, 2'd0, 32'd0, 1'b0, 32'd0, "add_5_7");
        do_op(3'd6, 32'd3, 32'd5, 2'd0, 2'd0, 32'd0, 1'b0, 32'd0, "sub_3_5");
        do_op(3'd7, 32'hFFFF_FFFF, 32'd1, 2'd0, 2'd0, 32'd0, 1'b0, 32'd0, "slt_m1_1");
        do_op(3'd7, 32'd1, 32'hFFFF_FFFF, 2'd0, 2'd0, 32'd0, 1'b0, 32'd0, "slt_1_m1");
        do_op(3'd0, 32'hF0F0_1234, 32'hFF00_FF0F, 2'd0, 2'd0, 32'd0, 1'b0, 32'd0, "and");
        do_op(3'd1, 32'hF0F0_1234, 32'h0F00_0F0F, 2'd0, 2'd0, 32'd0, 1'b0, 32'd0, "or");
        do_op(3'd4, 32'hAAAA_5555, 32'hFFFF_0000, 2'd0, 2'd0, 32'd0, 1'b0, 32'd0, "xor");
        do_op(3'd5, 32'hDEAD_BEEF, 32'h1, 2'd0, 2'd0, 32'd0, 1'b0, 32'd0, "op101");

        // Forwarding: A from alu_out_m (0x10), B from result_w (0x3)
        do_op(3'd2, 32'd8, 32'd8, 2'd0, 2'd0, 32'd0, 1'b0, 32'd0, "fwd_setup");
        do_op(3'd2, 32'hBAD0_0001, 32'hBAD0_0002, 2'd2, 2'd1, 32'd3, 1'b0, 32'd0, "fwd_add");
        do_op(3'd2, 32'd10, 32'hBAD0_0003, 2'd0, 2'd1, 32'h55, 1'b1, 32'hFFFF_FFFC, "alu_src_imm");
        do_op(3'd1, 32'h0000_00F0, 32'h0000_000F, 2'd3, 2'd3, 32'hFFFF_FFFF, 1'b0, 32'd0, "fwd_11");

        // Multiplier (or 0 when the unit is not built)
        do_op(3'd3, 32'h1234, 32'h10, 2'd0, 2'd0, 32'd0, 1'b0, 32'd0, "mul_1234_10");
        do_op(3'd3, 32'hFFFF_FFFF, 32'd2, 2'd0, 2'd0, 32'd0, 1'b0, 32'd0, "mul_b2b_1");
        do_op(3'd3, 32'd3, 32'd3, 2'd0, 2'd0, 32'd0, 1'b0, 32'd0, "mul_b2b_2");
        do_op(3'd3, 32'd0, 32'h1234_5678, 2'd0, 2'd0, 32'd0, 1'b0, 32'd0, "mul_zero");
        do_op(3'd2, 32'h20, 32'h1, 2'd0, 2'd0, 32'd0, 1'b0, 32'd0, "mul_fwd_setup");
        do_op(3'd3, 32'hBAD0_0004, 32'hBAD0_0005, 2'd2, 2'd1, 32'd5, 1'b0, 32'd0, "mul_fwd");

        // Reset asserted around iteration 10 of a MUL: no commit, then ADD 5+7
        alu_control_e = 3'd3; rd1_e = 32'd7; rd2_e = 32'd9;
        forward_a_e = 2'd0; forward_b_e = 2'd0; alu_src_e = 1'b0;
        reg_write_e = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("mid_reset.mul_busy", {31'd0, mul_busy}, 32'd0);
        chk_outputs("mid_reset", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        @(posedge clk); #1;
        chk_outputs("mid_reset_hold", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        alu_control_e = 3'd2;
        reset = 1'b1;
        exp_alu = 32'd0;
        do_op(3'd2, 32'd5, 32'd7, 2'd0, 2'd0, 32'd0, 1'b0, 32'd0, "post_reset_add");

        // Randomized instruction stream against the reference model
        for (int i = 0; i < 40; i++) begin
            do_op(3'($urandom), $urandom, $urandom, 2'($urandom), 2'($urandom),
                  $urandom, 1'($urandom), $urandom, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
